// File: rtl/scsp_eg.sv
// Time-multiplexed SCSP envelope generator: per-slot EVOL/state read-modify-write
// on each slot strobe, with rate scaling, key events and EG monitor readback.
module scsp_eg #(
  parameter int SLOTS  = 32,
  parameter int EVOL_W = 10,
  parameter int CNT_W  = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic [4:0]        SLOT,
  input  logic              KON,
  input  logic              KOFF,
  input  logic [4:0]        AR,
  input  logic [4:0]        D1R,
  input  logic [4:0]        D2R,
  input  logic [4:0]        RR,
  input  logic [4:0]        DL,
  input  logic [3:0]        KRS,
  input  logic [3:0]        OCT,
  input  logic              FNS9,
  input  logic              EGHOLD,
  input  logic              LPSLNK,
  input  logic              LOOP_START,
  input  logic [4:0]        MSLC,
  output logic [EVOL_W-1:0] EVOL_OUT,
  output logic [1:0]        ST_OUT,
  output logic [4:0]        SLOT_OUT,
  output logic              OUT_VALID,
  output logic [4:0]        MON_EG
);

  typedef enum logic [1:0] {
    ST_ATTACK  = 2'd0,
    ST_DECAY1  = 2'd1,
    ST_DECAY2  = 2'd2,
    ST_RELEASE = 2'd3
  } eg_state_t;

  localparam logic [EVOL_W-1:0] EVOL_MAX = {EVOL_W{1'b1}};

  // Rate scaling into the 6-bit effective rate; T is signed 8-bit, so bit 7 means negative.
  function automatic logic [5:0] eff_rate(input logic [4:0] r, input logic [3:0] krs,
                                          input logic fns9, input logic [3:0] oct);
    logic [7:0] t;
    if (r == 5'd0) begin
      t = 8'd0;
    end else if (krs == 4'hF) begin
      t = {2'b00, r, 1'b0};
    end else begin
      t = {4'h0, krs} + {7'h00, fns9} + {2'b00, r, 1'b0} + {4'h0, oct ^ 4'h8} - 8'd8;
    end
    if (t[7]) begin
      eff_rate = 6'd0;
    end else if (t >= 8'h3C) begin
      eff_rate = 6'h3C;
    end else begin
      eff_rate = t[5:0];
    end
  endfunction

  eg_state_t         st_r   [SLOTS];
  logic [EVOL_W-1:0] evol_r [SLOTS];
  logic [CNT_W-1:0]  cnt_r;

  eg_state_t         cur_st_s, nxt_st_s;
  logic [EVOL_W-1:0] cur_evol_s, nxt_evol_s, up_sat_s, dn_sat_s, out_evol_s;
  logic [EVOL_W:0]   up_s;
  logic [4:0]        rate_s, inc_s;
  logic [5:0]        e_s;
  logic [CNT_W-1:0]  mask_s;
  logic              step_s;

  // Next-state, step and output value for the slot being visited.
  always_comb begin
    cur_st_s   = st_r[SLOT];
    cur_evol_s = evol_r[SLOT];
    rate_s     = 5'd0;
    step_s     = 1'b0;
    inc_s      = 5'd0;
    mask_s     = {CNT_W{1'b0}};
    nxt_st_s   = cur_st_s;
    nxt_evol_s = cur_evol_s;

    if (KOFF && !KON) begin
      rate_s = RR;
    end else begin
      case (cur_st_s)
        ST_ATTACK:  rate_s = AR;
        ST_DECAY1:  rate_s = D1R;
        ST_DECAY2:  rate_s = D2R;
        ST_RELEASE: rate_s = RR;
        default:    rate_s = 5'd0;
      endcase
    end
    e_s = eff_rate(rate_s, KRS, FNS9, OCT);

    // Slow rates gate on low counter bits; fast rates step every sample with a larger increment.
    if (e_s == 6'd0) begin
      step_s = 1'b0;
    end else if (e_s < 6'h30) begin
      mask_s = (CNT_W'(1) << (4'd11 - e_s[5:2])) - CNT_W'(1);
      step_s = ((cnt_r & mask_s) == {CNT_W{1'b0}});
      inc_s  = 5'd1;
    end else begin
      step_s = 1'b1;
      inc_s  = 5'd1 << (e_s[5:2] - 4'd11);
    end

    up_s     = {1'b0, cur_evol_s} + {{(EVOL_W-6){1'b0}}, inc_s, 2'b00};
    up_sat_s = up_s[EVOL_W] ? EVOL_MAX : up_s[EVOL_W-1:0];
    if (cur_evol_s < {{(EVOL_W-5){1'b0}}, inc_s}) begin
      dn_sat_s = {EVOL_W{1'b0}};
    end else begin
      dn_sat_s = cur_evol_s - {{(EVOL_W-5){1'b0}}, inc_s};
    end

    if (KON) begin
      nxt_st_s   = ST_ATTACK;
      nxt_evol_s = {EVOL_W{1'b0}};
    end else if (KOFF) begin
      nxt_st_s   = ST_RELEASE;
      nxt_evol_s = step_s ? dn_sat_s : cur_evol_s;
    end else begin
      case (cur_st_s)
        ST_ATTACK: begin
          nxt_evol_s = step_s ? up_sat_s : cur_evol_s;
          if ((nxt_evol_s == EVOL_MAX) || (LPSLNK && LOOP_START)) begin
            nxt_st_s = ST_DECAY1;
          end else begin
            nxt_st_s = ST_ATTACK;
          end
        end
        ST_DECAY1: begin
          nxt_evol_s = step_s ? dn_sat_s : cur_evol_s;
          if (cur_evol_s[EVOL_W-1:EVOL_W-5] <= ~DL) begin
            nxt_st_s = ST_DECAY2;
          end else begin
            nxt_st_s = ST_DECAY1;
          end
        end
        ST_DECAY2, ST_RELEASE: begin
          nxt_evol_s = step_s ? dn_sat_s : cur_evol_s;
          nxt_st_s   = cur_st_s;
        end
        default: begin
          nxt_evol_s = cur_evol_s;
          nxt_st_s   = cur_st_s;
        end
      endcase
    end

    if ((nxt_st_s == ST_ATTACK) && EGHOLD) begin
      out_evol_s = EVOL_MAX;
    end else begin
      out_evol_s = nxt_evol_s;
    end
  end

  // Slot state array and sample counter write-back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SLOTS; i++) begin
        st_r[i]   <= ST_RELEASE;
        evol_r[i] <= {EVOL_W{1'b0}};
      end
      cnt_r <= {CNT_W{1'b0}};
    end else if (CE) begin
      st_r[SLOT]   <= nxt_st_s;
      evol_r[SLOT] <= nxt_evol_s;
      if (SLOT == 5'(SLOTS - 1)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Registered per-visit outputs and one-cycle valid pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EVOL_OUT  <= {EVOL_W{1'b0}};
      ST_OUT    <= 2'd0;
      SLOT_OUT  <= 5'd0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= CE;
      if (CE) begin
        EVOL_OUT <= out_evol_s;
        ST_OUT   <= nxt_st_s;
        SLOT_OUT <= SLOT;
      end
    end
  end

  assign MON_EG = evol_r[MSLC][EVOL_W-1:EVOL_W-5];

endmodule

// File: tb/tb_scsp_eg.sv
// Scoreboard bench for scsp_eg: directed slot sweeps push expected visits,
// a negedge monitor pops and compares every OUT_VALID.
module tb_scsp_eg;
  localparam logic [1:0] A = 2'd0, D1 = 2'd1, D2 = 2'd2, R = 2'd3;

  logic       CLK = 1'b0, RST = 1'b1, CE = 1'b0, KON = 1'b0, KOFF = 1'b0;
  logic [4:0] SLOT = 5'd0, AR = 5'd0, D1R = 5'd0, D2R = 5'd0, RR = 5'd0, DL = 5'd0, MSLC = 5'd3;
  logic [3:0] KRS = 4'hF, OCT = 4'h0;
  logic       FNS9 = 1'b0, EGHOLD = 1'b0, LPSLNK = 1'b0, LOOP_START = 1'b0;
  logic [9:0] EVOL_OUT;
  logic [1:0] ST_OUT;
  logic [4:0] SLOT_OUT, MON_EG;
  logic       OUT_VALID;

  scsp_eg dut (
    .CLK(CLK), .RST(RST), .CE(CE), .SLOT(SLOT), .KON(KON), .KOFF(KOFF),
    .AR(AR), .D1R(D1R), .D2R(D2R), .RR(RR), .DL(DL), .KRS(KRS), .OCT(OCT),
    .FNS9(FNS9), .EGHOLD(EGHOLD), .LPSLNK(LPSLNK), .LOOP_START(LOOP_START),
    .MSLC(MSLC), .EVOL_OUT(EVOL_OUT), .ST_OUT(ST_OUT), .SLOT_OUT(SLOT_OUT),
    .OUT_VALID(OUT_VALID), .MON_EG(MON_EG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       chk;
    logic [4:0] slot;
    logic [1:0] st;
    logic [9:0] evol;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   cnt_m = 0;

  function automatic void check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endfunction

  // Monitor: every valid output consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (OUT_VALID) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk) begin
          check("slot_out", int'(SLOT_OUT), int'(mon_e.slot));
          check("st_out", int'(ST_OUT), int'(mon_e.st));
          check("evol_out", int'(EVOL_OUT), int'(mon_e.evol));
        end
      end
    end
  end

  task automatic visit(input logic [4:0] s, input logic kon, input logic koff,
                       input logic chk, input logic [1:0] est, input logic [9:0] eevol);
    CE = 1'b1; SLOT = s; KON = kon; KOFF = koff;
    sbq.push_back('{chk: chk, slot: s, st: est, evol: eevol});
    @(posedge CLK); #1;
    CE = 1'b0; KON = 1'b0; KOFF = 1'b0;
  endtask

  // One full sample: slots 0..31, key events and checks aimed at slot 3 unless chk_all.
  task automatic sweep(input logic kon, input logic koff, input logic chk_all,
                       input logic [1:0] est, input logic [9:0] eevol,
                       input logic chkmon, input logic [4:0] emon);
    for (int s = 0; s < 32; s++) begin
      visit(5'(s), kon && (s == 3), koff && (s == 3), chk_all || (s == 3), est, eevol);
      if (chkmon && (s == 3)) check("mon_eg", int'(MON_EG), int'(emon));
    end
    cnt_m++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int v;
    logic [9:0] ev;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_evol_out", int'(EVOL_OUT), 0);
    check("rst_st_out", int'(ST_OUT), 0);
    check("rst_valid", int'(OUT_VALID), 0);
    check("rst_mon", int'(MON_EG), 0);
    RST = 1'b0;

    // Fast attack: +64 per sample, 0x3FF and DECAY1 on the 16th visit.
    AR = 5'h1F;
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);
    for (int k = 1; k <= 16; k++)
      sweep(1'b0, 1'b0, 1'b0, (k == 16) ? D1 : A, (k == 16) ? 10'h3FF : 10'(64 * k), 1'b0, 5'd0);

    // Decay1 with E=0x20: -1 when CNT[2:0]==0.
    D1R = 5'h10; DL = 5'h1F; ev = 10'h3FF;
    for (int k = 0; k < 16; k++) begin
      if (cnt_m % 8 == 0) ev = ev - 10'd1;
      sweep(1'b0, 1'b0, 1'b0, D1, ev, 1'b0, 5'd0);
    end
    DL = 5'h00;
    if (cnt_m % 8 == 0) ev = ev - 10'd1;
    sweep(1'b0, 1'b0, 1'b0, D2, ev, 1'b0, 5'd0);

    // Release from DECAY2 at full level: -16 per sample, floor at 0.
    AR = 5'h1F;
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);
    for (int k = 1; k <= 16; k++)
      sweep(1'b0, 1'b0, 1'b0, (k == 16) ? D1 : A, (k == 16) ? 10'h3FF : 10'(64 * k), 1'b0, 5'd0);
    D1R = 5'h00; DL = 5'h00; D2R = 5'h00;
    sweep(1'b0, 1'b0, 1'b0, D2, 10'h3FF, 1'b0, 5'd0);
    sweep(1'b0, 1'b0, 1'b0, D2, 10'h3FF, 1'b0, 5'd0);
    RR = 5'h1F;
    sweep(1'b0, 1'b1, 1'b0, R, 10'h3EF, 1'b0, 5'd0);
    for (int k = 2; k <= 66; k++) begin
      v = 1023 - 16 * k;
      if (v < 0) v = 0;
      sweep(1'b0, 1'b0, 1'b0, R, 10'(v), 1'b0, 5'd0);
    end

    // KON+KOFF together, then KON during release at 0x200.
    sweep(1'b1, 1'b1, 1'b0, A, 10'h000, 1'b0, 5'd0);
    for (int k = 1; k <= 8; k++)
      sweep(1'b0, 1'b0, 1'b0, A, 10'(64 * k), 1'b0, 5'd0);
    RR = 5'h00;
    sweep(1'b0, 1'b1, 1'b0, R, 10'h200, 1'b0, 5'd0);
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);

    // EGHOLD: output pinned at full, stored level visible on MON_EG.
    EGHOLD = 1'b1; MSLC = 5'd3;
    sweep(1'b1, 1'b0, 1'b0, A, 10'h3FF, 1'b1, 5'd0);
    for (int k = 1; k <= 3; k++)
      sweep(1'b0, 1'b0, 1'b0, A, 10'h3FF, 1'b1, 5'(2 * k));
    EGHOLD = 1'b0;

    // LPSLNK with LOOP_START at 0x100: step to 0x140 then DECAY1.
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);
    for (int k = 1; k <= 4; k++)
      sweep(1'b0, 1'b0, 1'b0, A, 10'(64 * k), 1'b0, 5'd0);
    LPSLNK = 1'b1; LOOP_START = 1'b1;
    sweep(1'b0, 1'b0, 1'b0, D1, 10'h140, 1'b0, 5'd0);
    LPSLNK = 1'b0; LOOP_START = 1'b0;

    // KRS=4, OCT=8, AR=0x1F: T=0x3A, inc 8, +32 per sample.
    KRS = 4'h4; OCT = 4'h8;
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);
    sweep(1'b0, 1'b0, 1'b0, A, 10'h020, 1'b0, 5'd0);
    sweep(1'b0, 1'b0, 1'b0, A, 10'h040, 1'b0, 5'd0);

    // KRS=0, OCT=8, AR=1: T=0xFA negative, E=0, level frozen.
    KRS = 4'h0; AR = 5'h01;
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);
    for (int k = 0; k < 9; k++)
      sweep(1'b0, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);

    // Asynchronous reset mid-attack.
    KRS = 4'hF; OCT = 4'h0; AR = 5'h1F;
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);
    for (int k = 1; k <= 3; k++)
      sweep(1'b0, 1'b0, 1'b0, A, 10'(64 * k), 1'b1, 5'(2 * k));
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("arst_evol_out", int'(EVOL_OUT), 0);
    check("arst_st_out", int'(ST_OUT), 0);
    check("arst_slot_out", int'(SLOT_OUT), 0);
    check("arst_valid", int'(OUT_VALID), 0);
    check("arst_mon", int'(MON_EG), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    cnt_m = 0;
    RR = 5'h1F;
    sweep(1'b0, 1'b0, 1'b1, R, 10'h000, 1'b0, 5'd0);

    // Counter restarts at 0: E=0x20 attack adds 4 only when CNT[2:0]==0.
    AR = 5'h10;
    sweep(1'b1, 1'b0, 1'b0, A, 10'h000, 1'b0, 5'd0);
    ev = 10'h000;
    for (int k = 0; k < 9; k++) begin
      if (cnt_m % 8 == 0) ev = ev + 10'd4;
      sweep(1'b0, 1'b0, 1'b0, A, ev, 1'b0, 5'd0);
    end

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scsp_eg.md
Name: scsp_eg

Overview:
- Time-multiplexed envelope generator for the 32 SCSP slots.
- On each slot strobe it reads one slot's stored envelope state (EVOL, ST), applies key events and rate stepping, writes the state back, and presents EVOL to the downstream total-level and volume stage.
- Sits directly upstream of the TL attenuation (EnvVolCalc) and also drives the CR4 EG monitor readback.

Parameters:
- SLOTS, 32, number of time-multiplexed slots; state array depth.
- EVOL_W, 10, envelope level width. 0x3FF = full level, 0 = silent.
- CNT_W, 12, width of the global sample counter used for rate stepping.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- CE  in  1  slot strobe; one slot is processed per CE cycle.
- SLOT  in  5  slot index being processed this CE.
- KON  in  1  key-on event for SLOT.
- KOFF  in  1  key-off event for SLOT.
- AR, D1R, D2R, RR  in  5 each  attack, decay1, decay2 and release rates.
- DL  in  5  decay level.
- KRS  in  4  key rate scaling.
- OCT  in  4  octave.
- FNS9  in  1  FNS[9].
- EGHOLD  in  1  hold output at full level during attack.
- LPSLNK  in  1  link the attack-to-decay1 transition to loop start.
- LOOP_START  in  1  address generator reached LSA for SLOT this sample.
- MSLC  in  5  monitored slot.
- EVOL_OUT  out  10  envelope level of SLOT_OUT.
- ST_OUT  out  2  EGState_t of SLOT_OUT.
- SLOT_OUT  out  5  slot index of the outputs.
- OUT_VALID  out  1  one-cycle pulse marking valid outputs.
- MON_EG  out  5  EVOL[9:5] of the MSLC slot, for CR4.EG.

Behaviour:
- Reset:
  - Every slot: ST = RELEASE, EVOL = 0.
  - All outputs 0.
  - Sample counter CNT = 0.
- Latency: state is updated on the CE edge. EVOL_OUT, ST_OUT and SLOT_OUT are registered on the same edge, and OUT_VALID is high for exactly the next cycle. Without CE, all state holds.
- Read-modify-write: the slot state is read combinationally and written back in the same cycle.
- CNT: increments by 1 on a CE cycle with SLOT == 31, after that slot is processed. It wraps modulo 2^CNT_W.
- Effective rate E (6 bit), computed from the R selected by the current ST:
  - R == 0: E = 0.
  - KRS == 0xF: T = {R,0}.
  - Otherwise: T = KRS + FNS9 + 2R + (OCT ^ 8) - 8, in 8-bit arithmetic.
  - Clamp: T[7] set → E = 0; T ≥ 0x3C → E = 0x3C; else E = T[5:0].
- Step (R[1:0] of E is ignored):
  - E == 0: no change.
  - E < 0x30: step when CNT[(11 - E[5:2]) - 1 : 0] == 0, with inc = 1.
  - E ≥ 0x30: step every sample, with inc = 1 << (E[5:2] - 11).
- State machine, applied in this priority order:
  1. KON: ST ← ATTACK, EVOL ← 0, no step this visit. KON wins over a simultaneous KOFF.
  2. KOFF: ST ← RELEASE from any state; the step is applied with RR.
  3. ATTACK (AR): on a step, EVOL ← min(EVOL + (inc << 2), 0x3FF). Go to DECAY1 when EVOL reaches 0x3FF, or when LPSLNK && LOOP_START. The transition is evaluated after the step.
  4. DECAY1 (D1R): on a step, EVOL ← max(EVOL - inc, 0). Go to DECAY2 when EVOL[9:5] ≤ ~DL. This is checked before the step, so DL = 0 exits at once.
  5. DECAY2 (D2R): decrement as in DECAY1; stays in DECAY2 at 0.
  6. RELEASE (RR): decrement; stays in RELEASE at 0.
- Saturation: no wrap in either direction. Widen to 11 bits for the add, then clamp.
- EGHOLD: while ST == ATTACK, EVOL_OUT = 0x3FF. The stored EVOL still rises.
- MON_EG: combinational read of state[MSLC].EVOL[9:5]. It reflects a write in the cycle after that write.
- Reset mid-operation: asynchronous. It clears all slot states, CNT and the outputs immediately.

Test Plan:
- Fast attack:
  - Stimulus: KRS=F, AR=0x1F, KON on slot 3, then CE sweeps 0..31 continuously.
  - Response: E = 0x3C, attack delta 64/sample. Slot 3 EVOL reads 64, 128, … on successive visits and reaches 0x3FF on the 16th, with ST → DECAY1 on that visit.
- Decay timing:
  - Stimulus: slot at 0x3FF in DECAY1, KRS=F, D1R=0x10, DL=0x1F.
  - Response: E = 0x20, so EVOL drops by 1 on every visit where CNT[2:0] == 0. Since ~DL = 0, the block goes to DECAY2 once EVOL[9:5] == 0, i.e. EVOL ≤ 0x1F.
- Release:
  - Stimulus: KOFF while slot is in DECAY2 at 0x3FF, KRS=F, RR=0x1F.
  - Response: ST = RELEASE, decrement 16/sample. EVOL reaches 0 after 64 samples and stays there.
- Simultaneous key events:
  - Stimulus: KON and KOFF in the same visit.
  - Response: ST = ATTACK, EVOL = 0.
  - Stimulus: KON during release at EVOL = 0x200.
  - Response: EVOL restarts from 0.
- EGHOLD and LPSLNK:
  - Stimulus: EGHOLD=1 during attack.
  - Response: EVOL_OUT = 0x3FF while the stored value (MON_EG with MSLC = slot) rises.
  - Stimulus: LPSLNK=1 with LOOP_START at EVOL = 0x100.
  - Response: ST → DECAY1 with EVOL = 0x100 + step.
- Reset and rate clamp:
  - Stimulus: assert RST mid-attack.
  - Response: all outputs 0 and OUT_VALID low; after release, every slot reads RELEASE/0.
  - Stimulus: KRS=0, OCT=8, R=1.
  - Response: T = 0xFA (T[7] set) → E = 0, so EVOL stays constant.
